// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO (1-cycle registered read latency) and sends each word
// as a UART frame: one start bit, DWIDTH data bits LSB first, one stop bit.
module fifo_uart_tx #(
  parameter int DWIDTH       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  input  logic [DWIDTH-1:0] i_fifo_data,
  output logic              o_fifo_rd_en,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DWIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DWIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [DWIDTH-1:0]   r_shift;
  logic                r_tx;
  logic                r_busy;
  logic                r_done;
  logic                w_pop;
  logic [DWIDTH-1:0]   w_shift_next;

  // Pop request: only from IDLE and never while the FIFO is empty or in reset
  always_comb begin
    w_pop = 1'b0;
    if ((r_state == S_IDLE) && i_enable && !i_fifo_empty && rst_n) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
  end

  assign w_shift_next = r_shift >> 1;

  // Frame sequencer; tx/busy/done are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_done <= 1'b0;
          if (w_pop) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_LOAD: begin
          // FIFO data is valid now, one cycle after the pop
          r_shift   <= i_fifo_data;
          r_baud    <= '0;
          r_bit_cnt <= '0;
          r_tx      <= 1'b0;
          r_state   <= S_START;
        end
        S_START: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud  <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud    <= '0;
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx    <= w_shift_next[0];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          // done is set one cycle early so it lands on the final stop cycle
          r_done <= (r_baud == BAUD_PRE);
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_rd_en = w_pop;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a frame-timeline model checks every cycle,
// plus literal expectations for the hand-worked frames.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int F   = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_fifo_empty;
  logic [DW-1:0] i_fifo_data = '0;
  logic          o_fifo_rd_en;
  logic          o_tx;
  logic          o_busy;
  logic          o_done;

  fifo_uart_tx #(.DWIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd_en (o_fifo_rd_en),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  // FIFO stand-in: main process writes, DUT pops with 1-cycle data latency
  logic [DW-1:0] mem [256];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr = 8'd0;
  int            cyc = 0;
  assign i_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_fifo_rd_en) begin
      i_fifo_data <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 8'd1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Model: m_t is the position inside the current frame (1 = cycle after the pop)
  int            m_t = -1;
  logic [DW-1:0] m_word = '0;
  logic [7:0]    m_rd = 8'd0;
  logic          e_tx, e_busy, e_done, e_rd;

  function automatic logic model_tx(input int t, input logic [DW-1:0] w);
    int k;
    if (t < 2 || t > F + 1) return 1'b1;
    k = (t - 2) / CPB;
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) m_t = -1;
    e_rd   = (m_t < 0) && rst_n && i_enable && !i_fifo_empty;
    e_busy = (m_t >= 1);
    e_done = (m_t == F + 1);
    e_tx   = model_tx(m_t, m_word);
    check("tx",    32'(o_tx),         32'(e_tx));
    check("busy",  32'(o_busy),       32'(e_busy));
    check("done",  32'(o_done),       32'(e_done));
    check("rd_en", 32'(o_fifo_rd_en), 32'(e_rd));
    if (e_rd) begin
      m_word = mem[m_rd];
      m_rd   = m_rd + 8'd1;
      m_t    = 1;
    end else if (m_t == F + 1) begin
      m_t = -1;
    end else if (m_t >= 1) begin
      m_t = m_t + 1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    @(posedge clk); #1;
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic set_en(input logic v);
    @(posedge clk); #1;
    i_enable = v;
  endtask

  task automatic wait_pop(output int n);
    n = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_fifo_rd_en) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) check("pop_timeout", 32'd0, 32'd1);
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic count_win(input int len, output int n_done, output int n_rd);
    n_done = 0;
    n_rd   = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (o_done) n_done++;
      if (o_fifo_rd_en) n_rd++;
    end
  endtask

  initial begin
    int n, nd, nr, d1, r2, cnt;

    // Reset held with clock running
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_tx",   32'(o_tx),   32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_tx", 32'(o_tx), 32'd1);

    // Single word 0xA5
    i_enable = 1'b1;
    push(8'hA5);
    wait_pop(n);
    at_cycle(n + 1);  check("a5_busy_n1",  32'(o_busy), 32'd1);
    at_cycle(n + 2);  check("a5_start_lo", 32'(o_tx),   32'd0);
    at_cycle(n + 5);  check("a5_start_hi", 32'(o_tx),   32'd0);
    at_cycle(n + 6);  check("a5_bit0",     32'(o_tx),   32'd1);
    at_cycle(n + 10); check("a5_bit1",     32'(o_tx),   32'd0);
    at_cycle(n + 34); check("a5_bit7",     32'(o_tx),   32'd1);
    at_cycle(n + 38); check("a5_stop",     32'(o_tx),   32'd1);
    at_cycle(n + 40); check("a5_done_n40", 32'(o_done), 32'd0);
    at_cycle(n + 41); check("a5_done_n41", 32'(o_done), 32'd1);
    check("a5_busy_n41", 32'(o_busy), 32'd1);
    at_cycle(n + 42); check("a5_busy_n42", 32'(o_busy), 32'd0);
    check("model_word_a5", 32'(m_word), 32'h0000_00A5);

    // Back-to-back 0x00 then 0xFF
    @(posedge clk); #1;
    mem[wr_ptr] = 8'h00; wr_ptr = wr_ptr + 8'd1;
    mem[wr_ptr] = 8'hFF; wr_ptr = wr_ptr + 8'd1;
    nd = 0; nr = 0; d1 = -1; r2 = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (o_done) begin
        nd++;
        if (d1 < 0) d1 = cyc;
      end
      if (o_fifo_rd_en) begin
        nr++;
        if (nr == 2) r2 = cyc;
      end
    end
    check("b2b_done_cnt", 32'(nd), 32'd2);
    check("b2b_rd_cnt",   32'(nr), 32'd2);
    check("b2b_gap",      32'(r2), 32'(d1 + 1));

    // Enabled but empty
    count_win(200, nd, nr);
    check("empty_rd",   32'(nr), 32'd0);
    check("empty_done", 32'(nd), 32'd0);

    // enable dropped during bit 3 of 0x3C with more data queued
    @(posedge clk); #1;
    mem[wr_ptr] = 8'h3C; wr_ptr = wr_ptr + 8'd1;
    mem[wr_ptr] = 8'h55; wr_ptr = wr_ptr + 8'd1;
    wait_pop(n);
    at_cycle(n + 18);
    check("3c_bit3", 32'(o_tx), 32'd1);
    set_en(1'b0);
    count_win(60, nd, nr);
    check("3c_done_cnt", 32'(nd), 32'd1);
    check("3c_rd_cnt",   32'(nr), 32'd0);
    check("3c_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
    set_en(1'b1);
    count_win(60, nd, nr);
    check("55_done_cnt", 32'(nd), 32'd1);

    // Asynchronous reset mid-DATA
    push(8'h3A);
    wait_pop(n);
    at_cycle(n + 15);
    @(posedge clk); #2;
    rst_n = 1'b0;
    i_enable = 1'b0;
    #1;
    check("async_tx",   32'(o_tx),   32'd1);
    check("async_busy", 32'(o_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    i_enable = 1'b1;
    push(8'h81);
    wait_pop(n);
    at_cycle(n + 6);  check("81_bit0", 32'(o_tx),   32'd1);
    at_cycle(n + 10); check("81_bit1", 32'(o_tx),   32'd0);
    at_cycle(n + 30); check("81_bit6", 32'(o_tx),   32'd0);
    at_cycle(n + 34); check("81_bit7", 32'(o_tx),   32'd1);
    at_cycle(n + 41); check("81_done", 32'(o_done), 32'd1);

    // Random traffic with enable toggling
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 50)) @(posedge clk);
      if ($urandom_range(0, 3) != 0) push(8'($urandom));
      if ($urandom_range(0, 2) == 0) set_en(1'($urandom));
    end
    set_en(1'b1);
    cnt = 0;
    while ((wr_ptr != rd_ptr || o_busy) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_timeout", 32'(cnt < 3000), 32'd1);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
